fpu_issue_ctrl: RTL and testbench

Issue controller and writeback arbiter for the FPU. It accepts one FP request per cycle from the decode stage and checks source and destination registers against a 32-entry scoreboard. It dispatches add/sub to fpu_add and div to the multi-cycle divider. It merges add-pipe and divider completions onto a single register-file writeback port, with add results taking priority.

---
 rtl/fpu_issue_ctrl_if.sv | 42 ++++
 rtl/fpu_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: request, dispatch, completion and writeback signals of the FPU issue controller
interface fpu_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_src_a;
  logic [4:0]  req_src_b;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_dest;
  logic        fpu_add_start;
  logic        fpu_add_sub;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [4:0]  fpu_dest;
  logic        div_start;
  logic        div_done;
  logic [31:0] div_result;
  logic [4:0]  div_dest;
  logic        div_ack;
  logic        add_valid;
  logic [31:0] add_result;
  logic [4:0]  add_dest;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [31:0] busy_mask;
  logic        err_illegal;
  logic        err_div_timeout;
  modport master (
    output req_valid, req_op, req_src_a, req_src_b, req_a, req_b, req_dest,
    output div_done, div_result, div_dest, add_valid, add_result, add_dest,
    input  req_ready, fpu_add_start, fpu_add_sub, fpu_a, fpu_b, fpu_dest, div_start, div_ack,
    input  wb_valid, wb_dest, wb_data, busy_mask, err_illegal, err_div_timeout
  );
  modport slave (
    input  req_valid, req_op, req_src_a, req_src_b, req_a, req_b, req_dest,
    input  div_done, div_result, div_dest, add_valid, add_result, add_dest,
    output req_ready, fpu_add_start, fpu_add_sub, fpu_a, fpu_b, fpu_dest, div_start, div_ack,
    output wb_valid, wb_dest, wb_data, busy_mask, err_illegal, err_div_timeout
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: scoreboarded FP issue and add/div writeback arbiter; define FPU_SB_BYPASS_EN to let a dependent op issue on its producer's writeback cycle
module fpu_issue_ctrl #(
  parameter int DIV_TIMEOUT = 64
) (
  input logic clock,
  input logic reset,
  fpu_issue_ctrl_if.slave bus
);
  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  typedef enum logic {D_IDLE, D_RUN} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0] r_div_dest;
  logic [31:0] r_busy;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0] r_dest;
  logic r_add_start;
  logic r_sub;
  logic r_div_start;
  logic r_wb_valid;
  logic [4:0] r_wb_dest;
  logic [31:0] r_wb_data;
  logic r_ill;
  logic r_to;
  logic w_ack;
  logic w_clr;
  logic [4:0] w_cd;
  logic [31:0] w_clr_mask;
  logic [31:0] w_hz_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_to_mask;
  logic w_hz;
  logic w_is_add;
  logic w_is_div;
  logic w_is_ill;
  logic w_dv;
  logic w_acc;
  logic w_timeout;
  assign w_ack = !reset && !bus.add_valid && bus.div_done;
  assign w_clr = bus.add_valid || w_ack;
  assign w_cd = bus.add_valid ? bus.add_dest : bus.div_dest;
  assign w_clr_mask = w_clr ? 32'(1) << w_cd : '0;
`ifdef FPU_SB_BYPASS_EN
  assign w_hz_mask = r_busy & ~w_clr_mask;
`else
  assign w_hz_mask = r_busy;
`endif
  assign w_hz = w_hz_mask[bus.req_src_a] | w_hz_mask[bus.req_src_b] | w_hz_mask[bus.req_dest];
  assign w_is_add = !bus.req_op[1];
  assign w_is_div = bus.req_op == 2'b10;
  assign w_is_ill = bus.req_op == 2'b11;
  assign w_dv = w_is_div && r_state != D_IDLE;
  assign bus.req_ready = !reset && (w_is_ill || (!w_hz && !w_dv));
  assign w_acc = bus.req_valid && bus.req_ready;
  assign w_timeout = r_state == D_RUN && !w_ack && r_cnt == CW'(DIV_TIMEOUT - 1);
  assign w_to_mask = w_timeout ? 32'(1) << r_div_dest : '0;
  assign w_set_mask = (w_acc && !w_is_ill) ? 32'(1) << bus.req_dest : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= D_IDLE;
      r_cnt <= '0;
      r_div_dest <= '0;
      r_busy <= '0;
      r_a <= '0;
      r_b <= '0;
      r_dest <= '0;
      r_add_start <= 1'b0;
      r_sub <= 1'b0;
      r_div_start <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_dest <= '0;
      r_wb_data <= '0;
      r_ill <= 1'b0;
      r_to <= 1'b0;
    end else begin
      r_add_start <= w_acc && w_is_add;
      r_div_start <= w_acc && w_is_div;
      r_ill <= w_acc && w_is_ill;
      r_to <= w_timeout;
      if (w_acc && !w_is_ill) begin
        r_a <= bus.req_a;
        r_b <= bus.req_b;
        r_dest <= bus.req_dest;
      end
      if (w_acc && w_is_add)
        r_sub <= bus.req_op[0];
      r_wb_valid <= w_clr;
      if (w_clr) begin
        r_wb_dest <= w_cd;
        r_wb_data <= bus.add_valid ? bus.add_result : bus.div_result;
      end
      // set is applied after clears so a same-index set survives
      r_busy <= (r_busy & ~w_clr_mask & ~w_to_mask) | w_set_mask;
      if (r_state == D_IDLE) begin
        r_cnt <= '0;
        if (w_acc && w_is_div) begin
          r_state <= D_RUN;
          r_div_dest <= bus.req_dest;
        end
      end else if (w_ack || w_timeout) begin
        r_state <= D_IDLE;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
  assign bus.fpu_add_start = r_add_start;
  assign bus.fpu_add_sub = r_sub;
  assign bus.fpu_a = r_a;
  assign bus.fpu_b = r_b;
  assign bus.fpu_dest = r_dest;
  assign bus.div_start = r_div_start;
  assign bus.div_ack = w_ack;
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_dest = r_wb_dest;
  assign bus.wb_data = r_wb_data;
  assign bus.busy_mask = r_busy;
  assign bus.err_illegal = r_ill;
  assign bus.err_div_timeout = r_to;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed and randomized checks of fpu_issue_ctrl against a cycle-level reference model
module tb_fpu_issue_ctrl;
  localparam int DIV_TIMEOUT = 64;
  localparam int ADD_LAT = 3;
`ifdef FPU_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  fpu_issue_ctrl_if bus();
  fpu_issue_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT)) dut (.clock(clock), .reset(reset), .bus(bus));
  int errs = 0;
  int checks = 0;
  logic [31:0] m_busy;
  bit m_run;
  int m_start;
  int m_dest;
  int edge_n = 0;
  bit last_ack;
  logic e_as, e_sub, e_ds, e_wbv, e_ill, e_to;
  logic [31:0] e_a, e_b, e_wbdat;
  logic [4:0] e_dest, e_wbd;
  typedef struct {int due; logic [4:0] d; logic [31:0] r;} add_t;
  add_t aq[$];
  int cyc = 0;
  bit dv_pend, dv_never;
  int dv_due;
  logic [4:0] dv_d;
  logic [31:0] dv_r;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit bz(input int i, input bit clr, input int cd);
    return m_busy[i] && !(BYP && clr && i == cd);
  endfunction
  task automatic idle_in();
    bus.req_valid = 0; bus.req_op = 0; bus.req_src_a = 0; bus.req_src_b = 0;
    bus.req_a = 0; bus.req_b = 0; bus.req_dest = 0;
    bus.div_done = 0; bus.div_result = 0; bus.div_dest = 0;
    bus.add_valid = 0; bus.add_result = 0; bus.add_dest = 0;
  endtask
  task automatic req(input logic [1:0] op, input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] d,
                     input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1; bus.req_op = op; bus.req_src_a = sa; bus.req_src_b = sb;
    bus.req_dest = d; bus.req_a = a; bus.req_b = b;
  endtask
  task automatic step();
    logic v, av, dn, rs;
    logic [1:0] op;
    logic [4:0] sa, sb, d, ad, dd;
    logic [31:0] a, b, ar, dr;
    bit ack, clr, hz, rdy, acc;
    int cd;
    #2;
    v = bus.req_valid; op = bus.req_op; sa = bus.req_src_a; sb = bus.req_src_b; d = bus.req_dest;
    a = bus.req_a; b = bus.req_b; av = bus.add_valid; ad = bus.add_dest; ar = bus.add_result;
    dn = bus.div_done; dd = bus.div_dest; dr = bus.div_result; rs = reset;
    ack = !rs && !av && dn;
    clr = av || ack;
    cd = av ? int'(ad) : int'(dd);
    hz = bz(sa, clr, cd) || bz(sb, clr, cd) || bz(d, clr, cd);
    rdy = !rs && (op == 2'b11 || (!hz && !(op == 2'b10 && m_run)));
    check("req_ready", {31'b0, bus.req_ready}, {31'b0, rdy});
    check("div_ack", {31'b0, bus.div_ack}, {31'b0, ack});
    acc = v && rdy;
    last_ack = ack;
    @(posedge clock);
    edge_n++;
    if (rs) begin
      m_busy = 0; m_run = 0;
      {e_as, e_sub, e_ds, e_wbv, e_ill, e_to} = '0;
      e_a = 0; e_b = 0; e_wbdat = 0; e_dest = 0; e_wbd = 0;
    end else begin
      e_as = acc && op < 2;
      e_ds = acc && op == 2;
      e_ill = acc && op == 3;
      if (acc && op < 3) begin e_a = a; e_b = b; e_dest = d; end
      if (acc && op < 2) e_sub = op[0];
      e_to = 0;
      if (m_run && ack) m_run = 0;
      else if (m_run && edge_n - m_start == DIV_TIMEOUT) begin
        e_to = 1; m_run = 0; m_busy[m_dest] = 0;
      end
      e_wbv = clr;
      if (av) begin e_wbd = ad; e_wbdat = ar; m_busy[ad] = 0; end
      else if (ack) begin e_wbd = dd; e_wbdat = dr; m_busy[dd] = 0; end
      if (acc && op < 3) m_busy[d] = 1;
      if (acc && op == 2) begin m_run = 1; m_start = edge_n; m_dest = d; end
    end
    #1;
    check("fpu_add_start", {31'b0, bus.fpu_add_start}, {31'b0, e_as});
    check("fpu_add_sub", {31'b0, bus.fpu_add_sub}, {31'b0, e_sub});
    check("fpu_a", bus.fpu_a, e_a);
    check("fpu_b", bus.fpu_b, e_b);
    check("fpu_dest", {27'b0, bus.fpu_dest}, {27'b0, e_dest});
    check("div_start", {31'b0, bus.div_start}, {31'b0, e_ds});
    check("wb_valid", {31'b0, bus.wb_valid}, {31'b0, e_wbv});
    check("wb_dest", {27'b0, bus.wb_dest}, {27'b0, e_wbd});
    check("wb_data", bus.wb_data, e_wbdat);
    check("busy_mask", bus.busy_mask, m_busy);
    check("err_illegal", {31'b0, bus.err_illegal}, {31'b0, e_ill});
    check("err_div_timeout", {31'b0, bus.err_div_timeout}, {31'b0, e_to});
  endtask
  task automatic env_observe();
    cyc++;
    if (last_ack) dv_pend = 0;
    if (bus.err_div_timeout) dv_pend = 0;
    if (bus.fpu_add_start) aq.push_back('{cyc + ADD_LAT, bus.fpu_dest, $urandom});
    if (bus.div_start) begin
      dv_pend = 1; dv_d = bus.fpu_dest; dv_r = $urandom;
      dv_never = $urandom_range(0, 5) == 0;
      dv_due = cyc + int'($urandom_range(1, 30));
    end
  endtask
  task automatic env_drive();
    bus.add_valid = 0;
    if (aq.size() > 0 && aq[0].due <= cyc) begin
      bus.add_valid = 1; bus.add_dest = aq[0].d; bus.add_result = aq[0].r;
      void'(aq.pop_front());
    end
    bus.div_done = dv_pend && !dv_never && cyc >= dv_due;
    bus.div_dest = dv_d; bus.div_result = dv_r;
    bus.req_valid = $urandom_range(0, 3) != 0;
    bus.req_op = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    bus.req_src_a = 5'($urandom_range(0, 7)); bus.req_src_b = 5'($urandom_range(0, 7));
    bus.req_dest = 5'($urandom_range(0, 7));
    bus.req_a = $urandom; bus.req_b = $urandom;
  endtask
  initial begin
    int k_to;
    idle_in();
    m_busy = 0; m_run = 0;
    reset = 1;
    step(); step();
    check("rst_busy", bus.busy_mask, 32'h0);
    reset = 0;
    step();
    req(2'b00, 5'd0, 5'd1, 5'd3, 32'h3F800000, 32'h40000000);
    step();
    bus.req_valid = 0;
    check("add_start", {31'b0, bus.fpu_add_start}, 32'd1);
    check("add_dest3", {27'b0, bus.fpu_dest}, 32'd3);
    check("add_busy8", bus.busy_mask, 32'h8);
    step();
    bus.add_valid = 1; bus.add_dest = 3; bus.add_result = 32'h40400000;
    step();
    bus.add_valid = 0;
    check("add_wb", bus.wb_data, 32'h40400000);
    check("add_wb_clr", bus.busy_mask, 32'h0);
    req(2'b00, 5'd0, 5'd0, 5'd5, 32'h1, 32'h2);
    step();
    req(2'b01, 5'd5, 5'd0, 5'd6, 32'h3, 32'h4);
    step(); step();
    bus.add_valid = 1; bus.add_dest = 5; bus.add_result = 32'h55;
    step();
    bus.add_valid = 0;
    step();
    check("raw_issued", {31'b0, bus.busy_mask[6]}, 32'd1);
    bus.req_valid = 0;
    bus.add_valid = 1; bus.add_dest = 6; bus.add_result = 32'h66;
    step();
    bus.add_valid = 0;
    req(2'b10, 5'd10, 5'd11, 5'd7, 32'hA, 32'hB);
    step();
    req(2'b00, 5'd0, 5'd1, 5'd2, 32'hC, 32'hD);
    step();
    bus.req_valid = 0;
    bus.add_valid = 1; bus.add_dest = 2; bus.add_result = 32'h11111111;
    bus.div_done = 1; bus.div_dest = 7; bus.div_result = 32'h22222222;
    step();
    bus.add_valid = 0;
    check("coll_add_first", {27'b0, bus.wb_dest}, 32'd2);
    step();
    bus.div_done = 0;
    check("coll_div_second", bus.wb_data, 32'h22222222);
    step();
    req(2'b10, 5'd0, 5'd0, 5'd4, 32'h40, 32'h41);
    step();
    req(2'b10, 5'd0, 5'd0, 5'd6, 32'h60, 32'h61);
    step(); step();
    bus.div_done = 1; bus.div_dest = 4; bus.div_result = 32'h44;
    step();
    bus.div_done = 0;
    step();
    check("div2_start", {31'b0, bus.div_start}, 32'd1);
    check("div2_dest", {27'b0, bus.fpu_dest}, 32'd6);
    bus.req_valid = 0;
    bus.div_done = 1; bus.div_dest = 6; bus.div_result = 32'h66;
    step();
    bus.div_done = 0;
    req(2'b10, 5'd0, 5'd0, 5'd9, 32'h90, 32'h91);
    step();
    bus.req_valid = 0;
    k_to = 0;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (bus.err_div_timeout && k_to == 0) k_to = k;
    end
    check("wd_cycles", k_to, 64);
    check("wd_bit9", {31'b0, bus.busy_mask[9]}, 32'd0);
    req(2'b10, 5'd0, 5'd0, 5'd12, 32'hC0, 32'hC1);
    step();
    bus.req_valid = 0;
    step(); step();
    reset = 1;
    req(2'b00, 5'd0, 5'd0, 5'd13, 32'h1, 32'h1);
    step(); step();
    check("rst_mid_busy", bus.busy_mask, 32'h0);
    reset = 0;
    bus.req_valid = 0;
    step();
    req(2'b11, 5'd12, 5'd12, 5'd12, 32'h0, 32'h0);
    step();
    bus.req_valid = 0;
    check("illegal_err", {31'b0, bus.err_illegal}, 32'd1);
    check("illegal_nostart", {30'b0, bus.fpu_add_start, bus.div_start}, 32'd0);
    step();
    idle_in();
    reset = 1;
    step(); step();
    reset = 0;
    aq.delete(); dv_pend = 0; last_ack = 0;
    for (int i = 0; i < 4000; i++) begin
      env_drive();
      step();
      env_observe();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
